// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared types and helpers for the leaky integrate-and-fire neuron.
//   state_t       : FSM encoding (IDLE, ACCUM, UPDATE)
//   POT_W_DEFAULT : default membrane potential / accumulator width
//   idx_width()   : bit width of a synapse index for a given synapse count
// -----------------------------------------------------------------------------
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int POT_W_DEFAULT = 16;

    // Width needed to index n items; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_add.sv
// -----------------------------------------------------------------------------
// sat_add
// Unsigned saturating adder: sum = min(a + b, 2^W - 1).
// Ports:
//   a, b : W-bit unsigned operands
//   sum  : W-bit saturated result
// -----------------------------------------------------------------------------
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        // The carry out is the overflow flag; clamp to all ones.
        sum  = full[W] ? {W{1'b1}} : full[W-1:0];
    end

endmodule

// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
// Leaky integrate-and-fire neuron. Each accepted timestep snapshots the spike
// and weight vectors, accumulates the weights of active synapses one per
// cycle, applies leak, compares against threshold and pulses spike_o/done_o.
// Optional build macro: LIF_SPIKE_COUNT_EN adds a saturating 16-bit output
// spike counter (spike_count_o).
// Ports:
//   clk_i         : clock, all logic on posedge
//   rst_i         : synchronous active-high reset
//   step_valid_i  : new timestep offered
//   step_ready_o  : neuron idle, can accept a timestep
//   spikes_i      : presynaptic spikes, bit k pairs with weight k
//   weights_i     : flattened weights, weight k = [k*WIDTH_P +: WIDTH_P]
//   spike_o       : output spike, one-cycle pulse
//   done_o        : timestep complete, one-cycle pulse
//   potential_o   : registered membrane potential
//   spike_count_o : (LIF_SPIKE_COUNT_EN only) saturating spike count
// -----------------------------------------------------------------------------
module lif_neuron
    import lif_pkg::*;
#(
    parameter int                NUM_SYNAPSES  = 100,
    parameter int                WIDTH_P       = 8,
    parameter int                POT_W         = POT_W_DEFAULT,
    parameter logic [POT_W-1:0]  THRESHOLD     = POT_W'(1000),
    parameter int                LEAK_SHIFT    = 3,
    parameter int                REFRACT_STEPS = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          step_valid_i,
    output logic                          step_ready_o,
    input  logic [NUM_SYNAPSES-1:0]       spikes_i,
    input  logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_i,
    output logic                          spike_o,
    output logic                          done_o,
    output logic [POT_W-1:0]              potential_o
`ifdef LIF_SPIKE_COUNT_EN
    ,
    output logic [15:0]                   spike_count_o
`endif
);

    localparam int IDX_W = idx_width(NUM_SYNAPSES);
    localparam int REF_W = idx_width(REFRACT_STEPS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYNAPSES - 1);

    state_t                         state_q, state_d;
    logic [NUM_SYNAPSES-1:0]        spikes_q;
    logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_q;
    logic [POT_W-1:0]               acc_q;
    logic [IDX_W-1:0]               idx_q;
    logic [POT_W-1:0]               potential_q;
    logic [REF_W-1:0]               refract_q;

    logic [WIDTH_P-1:0]             w_cur;
    logic [POT_W-1:0]               w_ext;
    logic [POT_W-1:0]               acc_sum;
    logic [POT_W-1:0]               leaked;
    logic [POT_W-1:0]               v;
    logic                           accept;
    logic                           fire;

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    assign w_cur  = weights_q[idx_q*WIDTH_P +: WIDTH_P];
    assign w_ext  = {{(POT_W-WIDTH_P){1'b0}}, w_cur};
    // p - (p >> s) is always <= p, so the leak never underflows.
    assign leaked = potential_q - (potential_q >> LEAK_SHIFT);

    sat_add #(.W(POT_W)) u_acc_add (
        .a   (acc_q),
        .b   (w_ext),
        .sum (acc_sum)
    );

    sat_add #(.W(POT_W)) u_pot_add (
        .a   (leaked),
        .b   (acc_q),
        .sum (v)
    );

    // ---------------------------------------------------------------------
    // FSM next state and combinational outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        step_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                step_ready_o = 1'b1;
                if (step_valid_i) state_d = ACCUM;
            end
            ACCUM: begin
                if (idx_q == LAST_IDX) state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && step_valid_i;
    assign fire   = (state_q == UPDATE) && (refract_q == '0) && (v >= THRESHOLD);

    // ---------------------------------------------------------------------
    // Input snapshot
    // ---------------------------------------------------------------------
    // NOTE: these holding registers have no reset; they are always written
    // on the accept cycle before anything reads them.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            spikes_q  <= spikes_i;
            weights_q <= weights_i;
        end
    end

    // ---------------------------------------------------------------------
    // State, accumulator, potential, refractory counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments throughout, so every register sees
        // the pre-edge values of the others regardless of statement order.
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            potential_q <= '0;
            refract_q   <= '0;
            spike_o     <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            spike_o <= 1'b0;
            done_o  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (step_valid_i) begin
                        acc_q <= '0;
                        idx_q <= '0;
                    end
                end
                ACCUM: begin
                    // Input is ignored while refractory, so acc stays 0.
                    if (spikes_q[idx_q] && (refract_q == '0)) acc_q <= acc_sum;
                    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                end
                UPDATE: begin
                    done_o <= 1'b1;
                    if (refract_q != '0) begin
                        refract_q   <= refract_q - 1'b1;
                        potential_q <= v;
                    end else if (fire) begin
                        spike_o     <= 1'b1;
                        potential_q <= '0;
                        refract_q   <= REF_W'(REFRACT_STEPS);
                    end else begin
                        potential_q <= v;
                    end
                end
                default: ;
            endcase
        end
    end

    assign potential_o = potential_q;

    // ---------------------------------------------------------------------
    // Optional spike counter
    // ---------------------------------------------------------------------
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] spike_count_q;

    // Counts on the same edge that raises spike_o, so the count already
    // includes a spike while that spike is visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spike_count_q <= '0;
        end else if (fire && (spike_count_q != 16'hFFFF)) begin
            spike_count_q <= spike_count_q + 16'd1;
        end
    end

    assign spike_count_o = spike_count_q;
`else
    // Counter not built; neuron behaviour is unchanged.
`endif

endmodule

// File: tb/tb_lif_neuron.sv
module tb_lif_neuron;

    localparam int N = 4;

    typedef struct {
        bit      spike;
        int      pot;
        int      cnt;
        longint  acc_cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    always #5 clk_i = ~clk_i;

    // Main DUT: POT_W=16, THRESHOLD=100
    logic        step_valid;
    logic        step_ready;
    logic [3:0]  spikes;
    logic [31:0] weights;
    logic        spike;
    logic        done;
    logic [15:0] potential;

    // Saturation DUT: POT_W=9, THRESHOLD=511
    logic        step_valid2;
    logic        step_ready2;
    logic [3:0]  spikes2;
    logic [31:0] weights2;
    logic        spike2;
    logic        done2;
    logic [8:0]  potential2;
`ifdef LIF_SPIKE_COUNT_EN
    logic [15:0] spike_count;
    logic [15:0] spike_count2;
`endif

    lif_neuron #(
        .NUM_SYNAPSES(N), .WIDTH_P(8), .POT_W(16), .THRESHOLD(16'd100),
        .LEAK_SHIFT(3), .REFRACT_STEPS(2)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .step_valid_i (step_valid),
        .step_ready_o (step_ready),
        .spikes_i     (spikes),
        .weights_i    (weights),
        .spike_o      (spike),
        .done_o       (done),
        .potential_o  (potential)
`ifdef LIF_SPIKE_COUNT_EN
        ,
        .spike_count_o(spike_count)
`endif
    );

    lif_neuron #(
        .NUM_SYNAPSES(N), .WIDTH_P(8), .POT_W(9), .THRESHOLD(9'd511),
        .LEAK_SHIFT(3), .REFRACT_STEPS(2)
    ) dut_sat (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .step_valid_i (step_valid2),
        .step_ready_o (step_ready2),
        .spikes_i     (spikes2),
        .weights_i    (weights2),
        .spike_o      (spike2),
        .done_o       (done2),
        .potential_o  (potential2)
`ifdef LIF_SPIKE_COUNT_EN
        ,
        .spike_count_o(spike_count2)
`endif
    );

    int     n_cmp  = 0;
    int     n_fail = 0;
    longint cyc    = 0;
    longint last_acc = -1;
    exp_t   sb[$];
    exp_t   sb2[$];
    exp_t   e1, e2;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the main DUT
    always @(posedge clk_i) begin
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e1 = sb.pop_front();
                check("spike", spike, e1.spike);
                check("potential", potential, e1.pot);
                check("ready_with_done", step_ready, 1);
                check("latency", cyc - e1.acc_cyc, N + 2);
            end
        end else if (spike) begin
            check("spike_without_done", spike, 0);
        end
    end

    // Monitor for the saturation DUT
    always @(posedge clk_i) begin
        #1;
        if (done2) begin
            if (sb2.size() == 0) begin
                check("sat_unexpected_done", done2, 0);
            end else begin
                e2 = sb2.pop_front();
                check("sat_spike", spike2, e2.spike);
                check("sat_potential", potential2, e2.pot);
                check("sat_latency", cyc - e2.acc_cyc, N + 2);
`ifdef LIF_SPIKE_COUNT_EN
                check("sat_spike_count", spike_count2, e2.cnt);
`endif
            end
        end
    end

    // Offers a step to the main DUT. While the DUT is busy the data lines
    // carry random garbage, so only the accept-cycle values may matter.
    // Consecutive accepts (no reset in between) must be exactly N+2 apart.
    task automatic issue(input logic [3:0] sp, input logic [31:0] w,
                         input bit exp_sp, input int exp_pot,
                         input bit push, input bit hold);
        int   waited = 0;
        exp_t x;
        step_valid = 1'b1;
        while (!step_ready) begin
            spikes  = 4'($urandom);
            weights = $urandom;
            @(posedge clk_i); #1;
            waited++;
            if (waited > 100) begin
                check("ready_timeout", step_ready, 1);
                step_valid = 1'b0;
                return;
            end
        end
        spikes  = sp;
        weights = w;
        if (last_acc >= 0) check("b2b_accept", cyc - last_acc, N + 2);
        last_acc = cyc;
        if (push) begin
            x.spike   = exp_sp;
            x.pot     = exp_pot;
            x.cnt     = 0;
            x.acc_cyc = cyc;
            sb.push_back(x);
        end
        @(posedge clk_i); #1;
        if (!hold) step_valid = 1'b0;
        spikes  = 4'($urandom);
        weights = $urandom;
    endtask

    task automatic issue_sat(input logic [3:0] sp, input logic [31:0] w,
                             input bit exp_sp, input int exp_pot, input int exp_cnt);
        int   waited = 0;
        exp_t x;
        while (!step_ready2) begin
            @(posedge clk_i); #1;
            waited++;
            if (waited > 100) begin
                check("sat_ready_timeout", step_ready2, 1);
                return;
            end
        end
        step_valid2 = 1'b1;
        spikes2     = sp;
        weights2    = w;
        x.spike   = exp_sp;
        x.pot     = exp_pot;
        x.cnt     = exp_cnt;
        x.acc_cyc = cyc;
        sb2.push_back(x);
        @(posedge clk_i); #1;
        step_valid2 = 1'b0;
        spikes2     = 4'($urandom);
        weights2    = $urandom;
    endtask

    // Leak/integrate sequence with weights 10, spikes 0101: acc = 20 per step.
    int leak_pot[8] = '{20, 38, 54, 68, 80, 90, 99, 0};

    initial begin
        rst_i       = 1'b1;
        step_valid  = 1'b0;
        spikes      = '0;
        weights     = '0;
        step_valid2 = 1'b0;
        spikes2     = '0;
        weights2    = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        check("rst_ready", step_ready, 1);
        check("rst_potential", potential, 0);
        check("rst_spike", spike, 0);
        check("rst_done", done, 0);
        check("rst_sat_potential", potential2, 0);

        // Basic step followed by the leak/integrate sequence; 8th step fires
        for (int i = 0; i < 8; i++)
            issue(4'b0101, 32'h0A0A0A0A, (i == 7), leak_pot[i], 1'b1, 1'b0);

        // Refractory: two ignored steps, then v = 200 fires
        issue(4'b1111, 32'h32323232, 1'b0, 0, 1'b1, 1'b0);
        issue(4'b1111, 32'h32323232, 1'b0, 0, 1'b1, 1'b0);
        issue(4'b1111, 32'h32323232, 1'b1, 0, 1'b1, 1'b0);

        // Reset mid-step at idx = 2 (refract count is 2 going in)
        issue(4'b1111, 32'h32323232, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        last_acc = -1;
        check("midrst_ready", step_ready, 1);
        check("midrst_potential", potential, 0);
        check("midrst_spike", spike, 0);
        check("midrst_done", done, 0);
        repeat (8) @(posedge clk_i);
        #1;
        // Refract count cleared: this step integrates normally
        issue(4'b0101, 32'h0A0A0A0A, 1'b0, 20, 1'b1, 1'b0);

        // Backpressure: valid held high, garbage inputs while busy
        // weights {w3,w2,w1,w0} = {5,7,9,11}
        issue(4'b1010, 32'h0507090B, 1'b0, 32, 1'b1, 1'b1);
        issue(4'b0110, 32'h0507090B, 1'b0, 44, 1'b1, 1'b1);
        issue(4'b1111, 32'h0507090B, 1'b0, 71, 1'b1, 1'b1);
        issue(4'b0001, 32'h0507090B, 1'b0, 74, 1'b1, 1'b0);

        // Saturation (POT_W = 9): acc 510 below threshold, then clamped fire
        issue_sat(4'b0011, 32'hFFFFFFFF, 1'b0, 510, 0);
        issue_sat(4'b1111, 32'hFFFFFFFF, 1'b1, 0, 1);

        // Drain both scoreboards
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && sb2.size() == 0) break;
            @(posedge clk_i);
        end
        repeat (2) @(posedge clk_i);
        #2;
        check("scoreboard_drained", sb.size() + sb2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
